// File: rtl/nibble_add_driver.sv
// Purpose : drives one 4-bit operand pair at a time into an external adder and
//           captures / checks its result after a fixed LATENCY.
// Latency : accept edge + LATENCY + 1 to sampling edge; one transaction every LATENCY+2 cycles.
// Backpressure: in_ready is high only while idle; in_valid offered while busy is ignored.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   operand pair handshake; in_a, in_b are the operands
//   dut_op              registered {A, B} bus to the adder under test
//   dut_res             adder result bus (sum in [3:0], [7:4] must be zero)
//   res_valid           one-cycle pulse; res_data / mismatch describe the finished pair
//   res_data            captured dut_res, held until the next pulse
//   mismatch, err_count result check and saturating error count
//
// Build option: define NIBBLE_DRV_SELFCHECK_EN to include the result comparator and
// the error counter. Without it, mismatch and err_count are constant zero.
// LATENCY must lie in 1..15 (the wait counter is 4 bits wide).

module nibble_add_driver #(
  parameter int unsigned LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [7:0] dut_op,
  input  logic [7:0] dut_res,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       mismatch,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] op_q, op_d;
  logic       rv_q, rv_d;
  logic [7:0] rdata_q, rdata_d;

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE accepts, WAIT counts down the adder latency, CHECK samples.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = {in_a, in_b};
          cnt_d   = 4'(LATENCY);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Counter value 1 means the adder result becomes valid at this edge,
        // so the following edge (leaving CHECK) is the sampling edge.
        if (cnt_q == 4'd1) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        rdata_d = dut_res;
        rv_d    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 8'd0;
      rv_q    <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  // res_valid and in_ready rise together after the sampling edge, so a new
  // pair can be taken in the same cycle the previous result is presented.
  assign in_ready  = (state_q == S_IDLE);
  assign dut_op    = op_q;
  assign res_valid = rv_q;
  assign res_data  = rdata_q;

`ifdef NIBBLE_DRV_SELFCHECK_EN
  // ---------------------------------------------------------------------------
  // Result checker and saturating error counter.
  // ---------------------------------------------------------------------------
  logic       sample;
  logic [3:0] sum_nib;
  logic [7:0] expected;
  logic       mm_q, mm_d;
  logic [7:0] err_q, err_d;

  assign sample   = (state_q == S_CHECK);
  // 4-bit sum: the carry out of bit 3 is intentionally dropped.
  assign sum_nib  = op_q[7:4] + op_q[3:0];
  // Upper nibble must read back as zero; anything else counts as a mismatch.
  assign expected = {4'b0000, sum_nib};

  always_comb begin
    mm_d  = mm_q;
    err_d = err_q;
    if (sample) begin
      mm_d = (dut_res != expected);
      if ((dut_res != expected) && (err_q != 8'hFF)) begin
        err_d = err_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_q  <= 1'b0;
      err_q <= 8'd0;
    end else begin
      mm_q  <= mm_d;
      err_q <= err_d;
    end
  end

  assign mismatch  = mm_q;
  assign err_count = err_q;
`else
  assign mismatch  = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_nibble_add_driver.sv
`timescale 1ns/1ps
module tb_nibble_add_driver;

  localparam int NI = 2;   // instance 0: LATENCY=1, instance 1: LATENCY=4

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      [NI];
  logic       in_valid [NI];
  logic [3:0] in_a     [NI];
  logic [3:0] in_b     [NI];
  logic [1:0] mode     [NI];   // adder behaviour: 0 ok, 1 upper nibble 1, 2 all ones, 3 flip sum bit0
  logic       in_ready [NI];
  logic [7:0] dut_op   [NI];
  logic [7:0] dut_res  [NI];
  logic       res_valid[NI];
  logic [7:0] res_data [NI];
  logic       mismatch [NI];
  logic [7:0] err_count[NI];

  int total = 0;
  int bad   = 0;

  nibble_add_driver #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .dut_op(dut_op[0]), .dut_res(dut_res[0]),
    .res_valid(res_valid[0]), .res_data(res_data[0]), .mismatch(mismatch[0]),
    .err_count(err_count[0])
  );

  nibble_add_driver #(.LATENCY(4)) u_dut4 (
    .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .dut_op(dut_op[1]), .dut_res(dut_res[1]),
    .res_valid(res_valid[1]), .res_data(res_data[1]), .mismatch(mismatch[1]),
    .err_count(err_count[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Behaviour of the external adder for a given fault mode.
  function automatic logic [7:0] adder_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] m);
    logic [7:0] s;
    s = 8'((int'(a) + int'(b)) % 16);
    case (m)
      2'd0:    return s;
      2'd1:    return s | 8'h10;
      2'd2:    return 8'hFF;
      default: return s ^ 8'h01;
    endcase
  endfunction

  // Registered adder models: result visible LATENCY edges after dut_op changes.
  logic [7:0] pipe1;
  logic [7:0] pipe4 [4];
  always @(posedge clk) begin
    pipe1    <= adder_ref(dut_op[0][7:4], dut_op[0][3:0], mode[0]);
    pipe4[0] <= adder_ref(dut_op[1][7:4], dut_op[1][3:0], mode[1]);
    for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
  end
  assign dut_res[0] = pipe1;
  assign dut_res[1] = pipe4[3];

  // ---------------------------------------------------------------------------
  // Reference model: a pair is taken when offered and the block has been free;
  // each pair occupies the block for LATENCY+2 cycles.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] res;
    logic       mm;
    logic [7:0] errc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t make_exp(input logic [3:0] a, input logic [3:0] b,
                                    input logic [1:0] m, input logic [7:0] errc);
    exp_t       e;
    logic [7:0] want;
    logic       chk_en;
`ifdef NIBBLE_DRV_SELFCHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    want   = 8'((int'(a) + int'(b)) % 16);
    e.res  = adder_ref(a, b, m);
    e.mm   = chk_en && (e.res != want);
    e.errc = (e.mm && errc != 8'd255) ? errc + 8'd1 : errc;
    return e;
  endfunction

  int         cyc       [NI];
  int         busy_until[NI];
  logic       pend      [NI];
  exp_t       pend_e    [NI];
  logic [7:0] m_op      [NI];
  logic [7:0] m_res     [NI];
  logic       m_mm      [NI];
  logic [7:0] m_err_show[NI];
  logic [7:0] m_err_acc [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        cyc[i]        <= 0;
        busy_until[i] <= -1;
        pend[i]       <= 1'b0;
        m_op[i]       <= 8'd0;
        m_res[i]      <= 8'd0;
        m_mm[i]       <= 1'b0;
        m_err_show[i] <= 8'd0;
        m_err_acc[i]  <= 8'd0;
        if (i == 0) q0.delete(); else q1.delete();
      end else begin
        cyc[i] <= cyc[i] + 1;
        if (pend[i] && cyc[i] == busy_until[i]) begin
          m_res[i]      <= pend_e[i].res;
          m_mm[i]       <= pend_e[i].mm;
          m_err_show[i] <= pend_e[i].errc;
        end
        if (in_valid[i] && cyc[i] > busy_until[i]) begin
          pend[i]       <= 1'b1;
          busy_until[i] <= cyc[i] + lat(i) + 1;
          m_op[i]       <= {in_a[i], in_b[i]};
          pend_e[i]     <= make_exp(in_a[i], in_b[i], mode[i], m_err_acc[i]);
          m_err_acc[i]  <= make_exp(in_a[i], in_b[i], mode[i], m_err_acc[i]).errc;
          if (i == 0) q0.push_back(make_exp(in_a[i], in_b[i], mode[i], m_err_acc[i]));
          else        q1.push_back(make_exp(in_a[i], in_b[i], mode[i], m_err_acc[i]));
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %02h expected %02h", nm, i, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: checks on the falling edge; pops the scoreboard on res_valid.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        chk("rst_in_ready",  i, 8'(in_ready[i]),  8'd1);
        chk("rst_res_valid", i, 8'(res_valid[i]), 8'd0);
        chk("rst_dut_op",    i, dut_op[i],        8'd0);
        chk("rst_res_data",  i, res_data[i],      8'd0);
        chk("rst_mismatch",  i, 8'(mismatch[i]),  8'd0);
        chk("rst_err_count", i, err_count[i],     8'd0);
      end else begin
        chk("in_ready",  i, 8'(in_ready[i]),  8'(cyc[i] > busy_until[i]));
        chk("res_valid", i, 8'(res_valid[i]), 8'(pend[i] && (cyc[i] - 1 == busy_until[i])));
        chk("dut_op",    i, dut_op[i],        m_op[i]);
        if (res_valid[i]) begin
          chk("sb_nonempty", i, 8'((i == 0 ? q0.size() : q1.size()) != 0), 8'd1);
          if (i == 0 && q0.size() != 0) begin
            chk("sb_res_data",  i, res_data[i],     q0[0].res);
            chk("sb_mismatch",  i, 8'(mismatch[i]), 8'(q0[0].mm));
            chk("sb_err_count", i, err_count[i],    q0[0].errc);
            void'(q0.pop_front());
          end else if (i == 1 && q1.size() != 0) begin
            chk("sb_res_data",  i, res_data[i],     q1[0].res);
            chk("sb_mismatch",  i, 8'(mismatch[i]), 8'(q1[0].mm));
            chk("sb_err_count", i, err_count[i],    q1[0].errc);
            void'(q1.pop_front());
          end
        end else begin
          chk("hold_res_data",  i, res_data[i],     m_res[i]);
          chk("hold_mismatch",  i, 8'(mismatch[i]), 8'(m_mm[i]));
          chk("hold_err_count", i, err_count[i],    m_err_show[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (!in_ready[i] && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL wait_idle_timeout dut%0d: in_ready still 0 after 40 cycles", i);
    end
  endtask

  // Offer a pair and hold it until the edge that takes it.
  task automatic send(input int i, input logic [3:0] a, input logic [3:0] b);
    in_valid[i] = 1'b1;
    in_a[i]     = a;
    in_b[i]     = b;
    wait_idle(i);
    tick();
    in_valid[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; in_a[i] = 4'd0; in_b[i] = 4'd0; mode[i] = 2'd0;
    end
    repeat (3) tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Basic pair, then the wrap case with a correct and an upper-nibble-faulty adder.
    send(0, 4'd3, 4'd4);  wait_idle(0);
    send(0, 4'd9, 4'd8);  wait_idle(0);
    mode[0] = 2'd1;
    send(0, 4'd9, 4'd8);  wait_idle(0);
    mode[0] = 2'd0;

    // in_valid held through the busy period while the operands change.
    in_valid[0] = 1'b1; in_a[0] = 4'd1; in_b[0] = 4'd1;
    tick();
    in_a[0] = 4'd2; in_b[0] = 4'd2;
    repeat (3) tick();
    in_valid[0] = 1'b0;
    wait_idle(0);

    // Random offers each cycle, one fault mode per block.
    for (int blk = 0; blk < 4; blk++) begin
      mode[0] = 2'(blk);
      repeat (60) begin
        in_valid[0] = 1'($urandom_range(0, 1));
        in_a[0]     = 4'($urandom_range(0, 15));
        in_b[0]     = 4'($urandom_range(0, 15));
        tick();
      end
      in_valid[0] = 1'b0;
      tick();
      wait_idle(0);
    end

    // Forced mismatches well past the counter limit, then a clean pair.
    mode[0] = 2'd3;
    repeat (260) send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    wait_idle(0);
    mode[0] = 2'd0;
    send(0, 4'd15, 4'd1); wait_idle(0);

    // LATENCY=4 instance: normal pair, all-ones adder, then reset during WAIT.
    send(1, 4'd5, 4'd6);  wait_idle(1);
    mode[1] = 2'd2;
    send(1, 4'd7, 4'd2);  wait_idle(1);
    mode[1] = 2'd0;
    send(1, 4'd7, 4'd7);
    repeat (1) tick();
    rst[1] = 1'b1;
    repeat (2) tick();
    rst[1] = 1'b0;
    send(1, 4'd2, 4'd3);  wait_idle(1);

    repeat (3) tick();
    chk("q0_drained", 0, 8'(q0.size()), 8'd0);
    chk("q1_drained", 1, 8'(q1.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
